// File: rtl/qs_ucode_ram_if.sv
// -----------------------------------------------------------------------------
// qs_ucode_ram_if
// Bus bundle between the sequencer (master) and the microcode store (slave).
//
// Handshake semantics:
//   Write: a beat transfers on a rising clk edge where wr_vld && wr_rdy.
//          wr_rdy depends only on the store's state, never on wr_vld.
//   Read:  a request is accepted on any edge where rd_vld is high outside of
//          init; rout_vld/rout/rout_oob follow one cycle later. There is no
//          read back-pressure.
//
// Signals (direction given from the slave's point of view):
//   rd_vld, rd_addr          in   read request and PC
//   rout_vld, rout, rout_oob out  registered read response
//   wr_vld, wr_addr, wr_data in   write request
//   wr_rdy                   out  write ready
//   lock                     in   level lock request
//   busy, locked, wr_err     out  status
//   dbg_state                out  FSM state, for debug and checkers
//   inj_perr, rout_perr           only with QS_UCODE_RAM_PARITY_EN defined
// -----------------------------------------------------------------------------
interface qs_ucode_ram_if #(
    parameter int PC_W   = 8,
    parameter int INST_W = 16
);
    logic              rd_vld;
    logic [PC_W-1:0]   rd_addr;
    logic              rout_vld;
    logic [INST_W-1:0] rout;
    logic              rout_oob;
    logic              wr_vld;
    logic              wr_rdy;
    logic [PC_W-1:0]   wr_addr;
    logic [INST_W-1:0] wr_data;
    logic              lock;
    logic              busy;
    logic              locked;
    logic              wr_err;
    logic [1:0]        dbg_state;
`ifdef QS_UCODE_RAM_PARITY_EN
    logic              inj_perr;
    logic              rout_perr;

    modport master (
        output rd_vld, rd_addr, wr_vld, wr_addr, wr_data, lock, inj_perr,
        input  rout_vld, rout, rout_oob, wr_rdy, busy, locked, wr_err,
               dbg_state, rout_perr
    );
    modport slave (
        input  rd_vld, rd_addr, wr_vld, wr_addr, wr_data, lock, inj_perr,
        output rout_vld, rout, rout_oob, wr_rdy, busy, locked, wr_err,
               dbg_state, rout_perr
    );
`else
    modport master (
        output rd_vld, rd_addr, wr_vld, wr_addr, wr_data, lock,
        input  rout_vld, rout, rout_oob, wr_rdy, busy, locked, wr_err,
               dbg_state
    );
    modport slave (
        input  rd_vld, rd_addr, wr_vld, wr_addr, wr_data, lock,
        output rout_vld, rout, rout_oob, wr_rdy, busy, locked, wr_err,
               dbg_state
    );
`endif
endinterface

// File: rtl/qs_ucode_ram.sv
// -----------------------------------------------------------------------------
// qs_ucode_ram
// Writable microcode control store sitting between the sequencer PC and the
// instruction decoder. After reset it fills every entry with FILL_INST
// (INIT, DEPTH cycles), then accepts program writes (RUN) until a sampled
// lock freezes the contents (LOCKED, left only by reset). Reads have one
// cycle of registered latency and are write-first against a same-cycle write.
//
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    qs_ucode_ram_if.slave (read port, write port, lock, status)
//
// Optional build macro:
//   QS_UCODE_RAM_PARITY_EN  adds an even-parity bit per entry, rout_perr on
//                           reads and the inj_perr write-side test hook.
// -----------------------------------------------------------------------------
module qs_ucode_ram #(
    parameter int                PC_W      = 8,
    parameter int                INST_W    = 16,
    parameter int                DEPTH     = 256,
    parameter logic [INST_W-1:0] FILL_INST = 16'h1080
) (
    input logic           clk,
    input logic           rst_n,
    qs_ucode_ram_if.slave bus
);

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    // With a full address space no address can be out of range, so the
    // range checks collapse to constant 0.
    localparam bit              FULL_RANGE = (DEPTH == (1 << PC_W));
    localparam logic [PC_W:0]   DEPTH_EXT  = (PC_W+1)'(DEPTH);
    localparam logic [PC_W-1:0] LAST_IDX   = PC_W'(DEPTH - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [PC_W-1:0]     r_cnt;

    logic [INST_W-1:0]   r_mem [0:DEPTH-1];

    logic                w_busy;
    logic                w_wr_rdy;
    logic                w_locked;

    logic                w_wr_acc;
    logic                w_wr_oob;
    logic                w_wr_ok;
    logic                w_mem_we;
    logic [PC_W-1:0]     w_mem_waddr;
    logic [INST_W-1:0]   w_mem_wdata;

    logic                w_rd_acc;
    logic                w_rd_oob;
    logic                w_bypass;
    logic [INST_W-1:0]   w_rd_inst;
    logic [INST_W-1:0]   w_rd_data;

    logic                r_rout_vld;
    logic [INST_W-1:0]   r_rout;
    logic                r_rout_oob;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_wr_rdy    = 1'b0;
        w_locked    = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_busy = 1'b1;
                if (r_cnt == LAST_IDX) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_wr_rdy = 1'b1;
                // A write accepted in this same cycle still lands.
                if (bus.lock) begin
                    w_state_nxt = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                w_locked = 1'b1;
            end
            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase
    end

    // Init fill pointer; only meaningful while in INIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_state == ST_INIT) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // ---------------------------------------------------------- write side
    always_comb begin
        w_wr_acc    = bus.wr_vld && w_wr_rdy;
        w_wr_oob    = FULL_RANGE ? 1'b0 : ({1'b0, bus.wr_addr} >= DEPTH_EXT);
        w_wr_ok     = w_wr_acc && !w_wr_oob;
        w_mem_we    = (r_state == ST_INIT) || w_wr_ok;
        w_mem_waddr = (r_state == ST_INIT) ? r_cnt : bus.wr_addr;
        w_mem_wdata = (r_state == ST_INIT) ? FILL_INST : bus.wr_data;
    end

    // Storage is deliberately not reset: INIT overwrites every entry.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_waddr] <= w_mem_wdata;
        end
    end

    // ----------------------------------------------------------- read side
    always_comb begin
        w_rd_acc  = bus.rd_vld && (r_state != ST_INIT);
        w_rd_oob  = FULL_RANGE ? 1'b0 : ({1'b0, bus.rd_addr} >= DEPTH_EXT);
        // Write-first: a same-cycle write to the read address is forwarded.
        w_bypass  = w_wr_ok && (bus.wr_addr == bus.rd_addr);
        w_rd_inst = w_bypass ? bus.wr_data : r_mem[bus.rd_addr];
        w_rd_data = w_rd_oob ? FILL_INST : w_rd_inst;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rout_vld <= 1'b0;
            r_rout     <= FILL_INST;
            r_rout_oob <= 1'b0;
        end else begin
            r_rout_vld <= w_rd_acc;
            if (w_rd_acc) begin
                r_rout     <= w_rd_data;
                r_rout_oob <= w_rd_oob;
            end
        end
    end

`ifdef QS_UCODE_RAM_PARITY_EN
    // ------------------------------------------------------------- parity
    localparam logic FILL_PAR = ^FILL_INST;

    logic r_par [0:DEPTH-1];
    logic w_mem_wpar;
    logic w_rd_par;
    logic w_rd_perr;
    logic r_rout_perr;

    always_comb begin
        // inj_perr flips the stored bit so a later read reports a mismatch.
        w_mem_wpar = (r_state == ST_INIT) ? FILL_PAR
                                          : ((^bus.wr_data) ^ bus.inj_perr);
        w_rd_par   = w_bypass ? w_mem_wpar : r_par[bus.rd_addr];
        w_rd_perr  = !w_rd_oob && ((^w_rd_inst) != w_rd_par);
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_par[w_mem_waddr] <= w_mem_wpar;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rout_perr <= 1'b0;
        end else if (w_rd_acc) begin
            r_rout_perr <= w_rd_perr;
        end
    end

    assign bus.rout_perr = r_rout_perr;
`endif

    // ------------------------------------------------------------ outputs
    assign bus.rout_vld  = r_rout_vld;
    assign bus.rout      = r_rout;
    assign bus.rout_oob  = r_rout_oob;
    assign bus.wr_rdy    = w_wr_rdy;
    assign bus.busy      = w_busy;
    assign bus.locked    = w_locked;
    assign bus.wr_err    = w_wr_acc && w_wr_oob;
    assign bus.dbg_state = r_state;

endmodule

// File: doc/qs_ucode_ram.md
Name: qs_ucode_ram

Overview:
Writable, parametrised microcode control store. It is the next-generation replacement for the hardwired quicksort control store. It sits between the sequencer PC and the instruction decoder.
- Program is loaded at run time through a valid/ready write port.
- Reads are registered, with one cycle of latency.
- The store initialises itself to a fill instruction after reset.
- A lock input freezes the contents once the program is loaded.

Parameters:
PC_W, 8, address (PC) width in bits.
INST_W, 16, instruction width in bits.
DEPTH, 256, number of entries; 1 <= DEPTH <= 2**PC_W; need not be a power of two.
FILL_INST, 16'h1080, value written to every entry during init; this is the encoding of "J 0x80", the error self-loop.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
rd_vld  in  1  read request
rd_addr  in  PC_W  read address (PC)
rout_vld  out  1  read data valid, one cycle after an accepted read
rout  out  INST_W  instruction
rout_oob  out  1  registered with rout; read address was >= DEPTH
wr_vld  in  1  write request
wr_rdy  out  1  write accepted when wr_vld && wr_rdy
wr_addr  in  PC_W  write address
wr_data  in  INST_W  write data
lock  in  1  level; sampled each cycle; once seen high, sets a sticky lock
busy  out  1  init in progress; reads and writes are not accepted
locked  out  1  sticky lock state
wr_err  out  1  one-cycle pulse on an accepted write with wr_addr >= DEPTH; the write is dropped

Behaviour:
Reset values:
- rout_vld=0, rout=FILL_INST, rout_oob=0.
- wr_rdy=0, busy=1, locked=0, wr_err=0.
- Init counter=0.
- Storage contents are not reset; they are overwritten by init.

FSM states: INIT, RUN, LOCKED.
- INIT:
  - Writes FILL_INST to entry cnt each cycle, then cnt++.
  - When cnt==DEPTH-1 is written, go to RUN next cycle.
  - Init takes exactly DEPTH cycles after reset deassertion.
  - busy=1 and wr_rdy=0 throughout. rd_vld is ignored; rout_vld stays 0.
- RUN:
  - busy=0, wr_rdy=1.
  - Accepted write with wr_addr<DEPTH updates the entry at the clock edge.
  - A sampled lock=1 goes to LOCKED next cycle. A write accepted in the same cycle still completes.
- LOCKED:
  - wr_rdy=0, locked=1.
  - Stays LOCKED until rst_n is asserted.

Reads (RUN and LOCKED):
- rd_vld at cycle N gives rout_vld=1 and rout=mem[rd_addr] at cycle N+1.
- rout and rout_oob hold their value when rd_vld=0. rout_vld=0 in that case.
- Back-to-back reads sustain 1 per cycle.
- Read and write to the same address in the same cycle is write-first: rout returns wr_data.
- Read with rd_addr>=DEPTH returns rout=FILL_INST with rout_oob=1.

Boundary conditions:
- DEPTH==1: INIT lasts 1 cycle.
- DEPTH==2**PC_W: no address is out of range; rout_oob and wr_err are tied 0.
- rst_n asserted mid-INIT, mid-write or mid-read: all outputs return to their reset values immediately (asynchronously), and INIT restarts from entry 0.
- wr_vld while busy or locked: no effect, no wr_err.
- lock high during INIT: ignored. Lock is sampled only in RUN.

Optional Feature:
QS_UCODE_RAM_PARITY_EN
- Defined:
  - Each entry stores an extra even-parity bit computed from the write data, or from FILL_INST during init.
  - A read recomputes parity; a mismatch asserts output rout_perr, registered with rout.
  - Out-of-range reads give rout_perr=0.
  - Test hook input inj_perr inverts the stored parity bit on an accepted write.
- Undefined:
  - Ports rout_perr and inj_perr are absent; there is no parity storage.

Test Plan:
1. Reset release, DEPTH=256 -> busy=1 for exactly 256 cycles, wr_rdy rises at cycle 256; read 0x00, 0x7F and 0xFF -> rout=16'h1080 each, rout_vld one cycle after rd_vld.
2. Write 0x20=16'hF000, 0x21=16'h6008 back-to-back, then read 0x20, 0x21 back-to-back -> rout 16'hF000, then 16'h6008, in consecutive cycles.
3. Same-cycle write 0x40=16'h2002 and read 0x40 -> next cycle rout=16'h2002.
4. DEPTH=200: write 0xC8 -> wr_err pulse, contents unchanged; read 0xC8 -> rout=16'h1080, rout_oob=1.
5. Pulse lock with a concurrent write 0x10=16'hAAAA -> write lands; locked=1 next cycle; later write 0x10=16'h5555 sees wr_rdy=0; read 0x10 -> 16'hAAAA.
6. Assert rst_n mid-INIT at cnt=100 -> rout_vld=0 and busy=1 immediately; after release, INIT runs a full 256 cycles. With QS_UCODE_RAM_PARITY_EN defined: write with inj_perr=1, read it back -> rout_perr=1.
